// File: rtl/vram_cpu_bridge.sv
// CPU-side requester for one 32-bit VRAM port: byte/half/word accesses become word cycles,
// sub-word stores use read-modify-write. Optional feature macro: VRAM_BYTE_DUP_EN.
module vram_cpu_bridge #(
    parameter int            AW         = 14,
    parameter int            RD_LATENCY = 0,
    parameter logic [AW-1:0] OBJ_BASE_W = 14'h3000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [1:0]    cpu_size_i,
    input  logic [AW+1:0] cpu_addr_i,
    input  logic [31:0]   cpu_wdata_i,
    output logic [31:0]   cpu_rdata_o,
    output logic          cpu_ack_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_din_o,
    input  logic [31:0]   mem_dout_i
);

`ifdef VRAM_BYTE_DUP_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    localparam int            CW       = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          half_q, half_d;
    logic [1:0]    lo_q, lo_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic          mwe_q, mwe_d;
    logic [31:0]   mdin_q, mdin_d;

    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   merged;
    logic          drop;

    // Sub-word merge against the word captured from VRAM this cycle.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata_q;
        if (half_q) begin
            be = lo_q[1] ? 4'b1100 : 4'b0011;
        end else if (DUP_EN) begin
            be     = lo_q[1] ? 4'b1100 : 4'b0011;
            wlanes = {4{wdata_q[{lo_q, 3'b000} +: 8]}};
        end else begin
            be = 4'b0001 << lo_q;
        end
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : mem_dout_i[8*i +: 8];
        drop = DUP_EN && !half_q && (maddr_q >= OBJ_BASE_W);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        half_d  = half_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        ack_d   = 1'b0;
        mwe_d   = 1'b0;
        case (state_q)
            S_IDLE: if (cpu_req_i) begin
                we_d    = cpu_we_i;
                half_d  = (cpu_size_i == 2'd1);
                lo_d    = cpu_addr_i[1:0];
                wdata_d = cpu_wdata_i;
                maddr_d = cpu_addr_i[AW+1:2];
                cnt_d   = '0;
                if (cpu_we_i && cpu_size_i[1]) begin
                    mdin_d  = cpu_wdata_i;
                    mwe_d   = 1'b1;
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        rdata_d = mem_dout_i;
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end else if (drop) begin
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        mdin_d  = merged;
                        mwe_d   = 1'b1;
                        state_d = S_WR;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR: begin
                ack_d   = 1'b1;
                state_d = S_ACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            lo_q    <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            maddr_q <= '0;
            mwe_q   <= 1'b0;
            mdin_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            maddr_q <= maddr_d;
            mwe_q   <= mwe_d;
            mdin_q  <= mdin_d;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ack_o   = ack_q;
    assign mem_addr_o  = maddr_q;
    assign mem_we_o    = mwe_q;
    assign mem_din_o   = mdin_q;

endmodule

// File: tb/tb_vram_cpu_bridge.sv
// Bench for vram_cpu_bridge: directed vector table, reset/back-to-back sequences, and
// randomized accesses checked against a byte-addressed memory model.
module tb_vram_cpu_bridge;
    localparam int AW  = 14;
    localparam int LAT = 2;
`ifdef VRAM_BYTE_DUP_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_ack, mem_we;
    logic [1:0]    cpu_size;
    logic [AW+1:0] cpu_addr;
    logic [31:0]   cpu_wdata, cpu_rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    vram_cpu_bridge #(.AW(AW), .RD_LATENCY(LAT), .OBJ_BASE_W(14'h3000)) dut (
        .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_size_i(cpu_size), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    // VRAM with a two-stage read pipeline (RD_LATENCY = 2)
    logic [31:0] vram [0:(1<<AW)-1];
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_din;
        p1 <= vram[mem_addr];
        p2 <= p1;
    end
    assign mem_dout = p2;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] last_rd = '0;
    logic [7:0]  refb [0:65535];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [15:0] a);
        int b = {16'h0, a[15:2], 2'b00};
        return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
    endfunction

    // Reference: byte-level memory, expected strobe/data/latency from access type.
    task automatic model(input logic we, input logic [1:0] sz, input logic [15:0] a,
                         input logic [31:0] wd, output logic ewe, output logic [31:0] edin,
                         output logic [31:0] erd, output int eack, output int ewel);
        int base = {16'h0, a[15:2], 2'b00};
        int h    = {16'h0, a[15:1], 1'b0};
        int ai   = {16'h0, a};
        ewe = 1'b0; edin = '0; ewel = -1; erd = mword(a);
        if (!we) begin
            eack = 2 + LAT;
        end else if (sz[1]) begin
            for (int i = 0; i < 4; i++) refb[base+i] = wd[8*i +: 8];
            ewe = 1'b1; ewel = 1; eack = 2;
        end else if (DUP && sz == 2'd0 && a[15:2] >= 14'h3000) begin
            eack = 2 + LAT;
        end else begin
            if (sz == 2'd1) begin
                refb[h]   = wd[8*(h % 4) +: 8];
                refb[h+1] = wd[8*((h+1) % 4) +: 8];
            end else if (DUP) begin
                refb[h]   = wd[8*(ai % 4) +: 8];
                refb[h+1] = wd[8*(ai % 4) +: 8];
            end else begin
                refb[ai]  = wd[8*(ai % 4) +: 8];
            end
            ewe = 1'b1; ewel = 2 + LAT; eack = 3 + LAT;
        end
        if (ewe) edin = mword(a);
    endtask

    // Called at a sample point with the DUT idle (or in ACK when skip=1).
    task automatic access(input logic we, input logic [1:0] sz, input logic [15:0] a,
                          input logic [31:0] wd, input logic ewe, input logic [31:0] edin,
                          input logic [31:0] erd, input int eack, input int ewel,
                          input int skip, input logic keep, input string nm);
        int          we_cnt = 0, we_at = -1, ack_at = -1;
        logic [13:0] we_addr = '0;
        logic [31:0] we_din = '0, rd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
        repeat (skip) begin
            @(posedge clk); #1;
            if (mem_we) we_cnt++;
        end
        @(posedge clk); #1;
        cpu_we = ~we; cpu_size = 2'($urandom); cpu_addr = 16'($urandom); cpu_wdata = $urandom;
        for (int n = 1; n <= 20; n++) begin
            if (mem_we) begin we_cnt++; we_at = n; we_addr = mem_addr; we_din = mem_din; end
            if (cpu_ack) begin ack_at = n; rd = cpu_rdata; break; end
            @(posedge clk); #1;
        end
        if (!keep || ack_at < 0) cpu_req = 1'b0;
        chk({nm, " ack_latency"}, 32'(ack_at), 32'(eack));
        chk({nm, " we_count"}, 32'(we_cnt), ewe ? 32'd1 : 32'd0);
        if (ewe) begin
            chk({nm, " we_latency"}, 32'(we_at), 32'(ewel));
            chk({nm, " mem_addr"}, 32'(we_addr), 32'(a[15:2]));
            chk({nm, " mem_din"}, we_din, edin);
        end
        if (!we) begin
            chk({nm, " rdata"}, rd, erd);
            last_rd = erd;
        end else begin
            chk({nm, " rdata_hold"}, rd, last_rd);
        end
        if (!keep) begin
            @(posedge clk); #1;
            chk({nm, " post_ack_quiet"}, {30'h0, cpu_ack, mem_we}, 32'h0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [31:0] wd;
        logic        ewe;
        logic [31:0] edin;
        logic [31:0] erd;
        int          eack;
        int          ewel;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic        ewe;
        logic [31:0] edin, erd;
        int          eack, ewel, we_seen, ack_seen;
        logic [15:0] a;

        tbl[0]  = '{1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0, 2, 1};
        tbl[1]  = '{1'b0, 2'd0, 16'h0010, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 4, -1};
        tbl[2]  = '{1'b1, 2'd1, 16'h0012, 32'h12340000, 1'b1, 32'h1234BEEF, 32'h0, 5, 4};
        tbl[3]  = '{1'b1, 2'd0, 16'h0011, 32'h00005500, 1'b1,
                    DUP ? 32'h12345555 : 32'h123455EF, 32'h0, 5, 4};
        tbl[4]  = '{1'b0, 2'd2, 16'h0010, 32'h0, 1'b0, 32'h0,
                    DUP ? 32'h12345555 : 32'h123455EF, 4, -1};
        tbl[5]  = '{1'b1, 2'd3, 16'hC000, 32'h11223344, 1'b1, 32'h11223344, 32'h0, 2, 1};
        tbl[6]  = '{1'b1, 2'd0, 16'hC000, 32'h000000AA, !DUP,
                    DUP ? 32'h0 : 32'h112233AA, 32'h0, DUP ? 4 : 5, DUP ? -1 : 4};
        tbl[7]  = '{1'b0, 2'd0, 16'hC003, 32'h0, 1'b0, 32'h0,
                    DUP ? 32'h11223344 : 32'h112233AA, 4, -1};
        tbl[8]  = '{1'b1, 2'd1, 16'h0013, 32'hABCD0000, 1'b1,
                    DUP ? 32'hABCD5555 : 32'hABCD55EF, 32'h0, 5, 4};
        tbl[9]  = '{1'b1, 2'd2, 16'h0017, 32'h01020304, 1'b1, 32'h01020304, 32'h0, 2, 1};
        tbl[10] = '{1'b0, 2'd1, 16'h0015, 32'h0, 1'b0, 32'h0, 32'h01020304, 4, -1};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", {31'h0, cpu_ack}, 32'h0);
        chk("reset mem_we", {31'h0, mem_we}, 32'h0);
        chk("reset rdata", cpu_rdata, 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset mem_din", mem_din, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, ewe, edin, erd, eack, ewel);
            access(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].ewe, tbl[i].edin,
                   tbl[i].erd, tbl[i].eack, tbl[i].ewel, 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset while a half write sits in RD: aborted, nothing reaches VRAM.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd1; cpu_addr = 16'h0012;
        cpu_wdata = 32'h99990000;
        @(posedge clk); #1;
        cpu_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst mem_addr", 32'(mem_addr), 32'h0);
        chk("midrst mem_din", mem_din, 32'h0);
        chk("midrst rdata", cpu_rdata, 32'h0);
        last_rd = '0;
        we_seen = 0; ack_seen = 0;
        repeat (8) begin
            if (mem_we) we_seen++;
            if (cpu_ack) ack_seen++;
            @(posedge clk); #1;
        end
        chk("midrst no_we", 32'(we_seen), 32'h0);
        chk("midrst no_ack", 32'(ack_seen), 32'h0);
        chk("midrst vram", vram[4], mword(16'h0010));
        model(1'b0, 2'd2, 16'h0010, 32'h0, ewe, edin, erd, eack, ewel);
        access(1'b0, 2'd2, 16'h0010, 32'h0, ewe, edin, erd, eack, ewel, 0, 1'b0, "after_rst");

        // Request held across ack: next access accepted exactly one cycle later.
        model(1'b1, 2'd2, 16'h0020, 32'hCAFEF00D, ewe, edin, erd, eack, ewel);
        access(1'b1, 2'd2, 16'h0020, 32'hCAFEF00D, ewe, edin, erd, eack, ewel, 0, 1'b1, "held_wr");
        model(1'b0, 2'd2, 16'h0020, 32'h0, ewe, edin, erd, eack, ewel);
        access(1'b0, 2'd2, 16'h0020, 32'h0, ewe, edin, erd, eack, ewel, 1, 1'b0, "held_rd");

        // Random traffic over words 0..7 and the first OBJ words.
        for (int i = 0; i < 12; i++) begin
            a = (i < 8) ? 16'(i * 4) : {14'h3000 + 14'(i - 8), 2'b00};
            model(1'b1, 2'd2, a, $urandom, ewe, edin, erd, eack, ewel);
            access(1'b1, 2'd2, a, {refb[a+3], refb[a+2], refb[a+1], refb[a]}, ewe, edin,
                   erd, eack, ewel, 0, 1'b0, $sformatf("init%0d", i));
        end
        for (int i = 0; i < 150; i++) begin
            int          ws = $urandom_range(0, 11);
            logic        we = 1'($urandom);
            logic [1:0]  sz = 2'($urandom);
            logic [31:0] wd = $urandom;
            logic [13:0] w  = (ws < 8) ? 14'(ws) : 14'h3000 + 14'(ws - 8);
            a = {w, 2'($urandom)};
            model(we, sz, a, wd, ewe, edin, erd, eack, ewel);
            access(we, sz, a, wd, ewe, edin, erd, eack, ewel, 0, 1'b0, $sformatf("rnd%0d", i));
            if (we) chk($sformatf("rnd%0d vram", i), vram[w], mword(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
